// File: rtl/repeat_add_multiplier.sv
// Sequential unsigned multiplier: A and B arrive in turn on a shared bus, and A is
// added into P B times while B counts down to zero. done stays high until start drops.
module repeat_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_reg, b_reg, p_reg;
  logic             ld_a, ld_b, add_en;
  logic             equal_z;

  assign equal_z = (b_reg == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the result depend on process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    next_state = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    add_en     = 1'b0;
    case (state)
      IDLE:   if (start) next_state = LOAD_A;
      LOAD_A: begin
        ld_a       = 1'b1;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        ld_b       = 1'b1;
        next_state = CALC;
      end
      CALC: begin
        if (equal_z) next_state = DONE;
        else         add_en     = 1'b1;
      end
      DONE:   if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // P is cleared when B is loaded, so a new operation never sees the previous result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
    end else begin
      if (ld_a) a_reg <= data_in;
      if (ld_b) begin
        b_reg <= data_in;
        p_reg <= '0;
      end
      if (add_en) begin
        p_reg <= p_reg + a_reg;
        b_reg <= b_reg - 1'b1;
      end
    end
  end

  assign product = p_reg;
  assign done    = (state == DONE);

endmodule

// File: tb/tb_repeat_add_multiplier.sv
// Directed bench for repeat_add_multiplier: hand-computed products and done latency,
// including the overflow, zero-operand, restart, start-glitch and mid-operation reset cases.
module tb_repeat_add_multiplier;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] product;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  repeat_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .product (product),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one operation from IDLE. Edge 1 samples start=1; data_in carries A through
  // edge 2 and B through edge 3. With glitch set, start toggles 1->0->1 during CALC.
  task automatic run_op(input string tag, input int a, input int b, input int exp_p,
                        input int exp_edge, input bit glitch);
    int edges = 0;
    @(negedge clk);
    start   = 1'b1;
    data_in = WIDTH'(a);
    while (!done && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 2) data_in = WIDTH'(b);
      if (glitch && edges == 5) start = 1'b0;
      if (glitch && edges == 6) start = 1'b1;
    end
    check({tag, " done_edge"}, edges, exp_edge);
    check({tag, " product"}, product, exp_p);
    repeat (2) @(negedge clk);
    check({tag, " done_held"}, done, 1'b1);
    check({tag, " product_held"}, product, exp_p);
    start   = 1'b0;
    data_in = 16'hDEAD;
    @(negedge clk);
    check({tag, " done_cleared"}, done, 1'b0);
    check({tag, " product_idle"}, product, exp_p);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    #1;
    check("reset product", product, 0);
    check("reset done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("basic",         15,   9,   135,  13, 1'b0);
    run_op("restart",        3,   4,    12,   8, 1'b0);
    run_op("zero_b",         7,   0,     0,   4, 1'b0);
    run_op("zero_a",         0,   5,     0,   9, 1'b0);
    run_op("overflow",     300, 300, 24464, 304, 1'b0);
    run_op("start_glitch",  15,   9,   135,  13, 1'b1);

    // Reset during the third addition of 15*9: P=45 after edge 6, then rst mid-cycle.
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'd15;
    @(negedge clk);
    @(negedge clk);
    data_in = 16'd9;
    repeat (4) @(negedge clk);
    check("midcalc progress", product, 45);
    #1 rst = 1'b1;
    #1;
    check("midcalc reset product", product, 0);
    check("midcalc reset done", done, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset idle product", product, 0);
    check("post_reset idle done", done, 0);

    run_op("after_reset",    6,   7,    42,  11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/repeat_add_multiplier.md
Name: repeat_add_multiplier

Overview:
- Sequential unsigned multiplier built from a datapath (A, B and P registers, adder, decrementer, zero detect) and an FSM controller.
- Both operands arrive one after the other on a shared 16-bit input bus: A first, then B.
- Computes P = A * B by adding A into P B times while B counts down to zero, then asserts done.
- Used as a low-area multiply unit where latency is not critical.

Parameters:
- WIDTH, 16, width of data_in, the A, B and P registers, and product.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request to begin an operation; level-sensitive, sampled on clk.
- data_in  input  WIDTH  operand bus: A is sampled in LOAD_A, B is sampled in LOAD_B.
- product  output  WIDTH  P register, (A*B) mod 2^WIDTH.
- done  output  1  high while the FSM is in DONE.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, A=0, B=0, P=0, so product=0 and done=0.
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE. Binary encoding; all outputs are decoded from registered state and registers (no combinational input-to-output path).
- IDLE:
  - start=1 at an edge -> LOAD_A.
  - Otherwise stay. A, B and P hold, so product keeps the last result.
- LOAD_A: at the edge, A<=data_in; -> LOAD_B.
- LOAD_B: at the edge, B<=data_in and P<=0 (clear); -> CALC.
- CALC, evaluated each edge on the current B:
  - B!=0: P<=P+A (truncated to WIDTH), B<=B-1, stay in CALC.
  - B==0: -> DONE; P and B unchanged.
  - Zero detect equalZ=(B==0) is combinational on the B register.
- DONE:
  - done=1; P holds.
  - Stay while start=1; -> IDLE when start=0 at an edge.
  - done deasserts on that edge.
- Latency: counting the edge that samples start=1 as edge 1:
  - A loaded at edge 2.
  - B loaded at edge 3.
  - Additions on edges 4 to B+3.
  - DONE entered at edge B+4.
  - Total B+4 edges.
- Arithmetic: unsigned; overflow wraps modulo 2^WIDTH with no flag.
- Boundaries:
  - B=0: no additions; product=0; DONE at edge 4.
  - A=0: B cycles of adding 0; product=0.
  - start changes during LOAD_A, LOAD_B or CALC: ignored.
  - rst mid-operation: immediate return to IDLE with all registers 0; no partial result retained.
  - Back-to-back operations require start to drop, which returns the FSM from DONE to IDLE. Start is then raised again.
- data_in is don't-care outside LOAD_A and LOAD_B.

Test Plan:
- Basic: rst pulse, start=1, data_in=15 in LOAD_A, data_in=9 in LOAD_B -> product=135; done rises at edge 13 and stays high while start=1.
- Zero multiplier: A=7, B=0 -> product=0; done at edge 4. Zero multiplicand: A=0, B=5 -> product=0; done at edge 9.
- Overflow: A=300, B=300 -> product=24464 (90000 mod 65536); done at edge 304.
- Restart: after the basic case, drop start -> FSM back in IDLE, done=0, product stays 135; raise start with A=3, B=4 -> product=12.
- Reset mid-CALC: assert rst asynchronously during iteration 3 of 15*9 -> product=0 and done=0 immediately; FSM in IDLE; no progress while start=0.
- Start glitch: toggle start 1->0->1 during CALC -> no effect; result still correct.
